// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl - instruction sequencer for the 8x8 weight-stationary core.
//
// For every kernel position kij it fetches a weight tile from xmem, loads it
// into the array, streams the activation block, then drains OFIFO rows into
// psum SRAM. The 34-bit instruction word is fully registered: the word seen on
// inst_o in cycle t+1 is computed from the state held in cycle t.
//
// Ports:
//   clk_i          clock
//   reset_i        synchronous, active-high reset
//   start_i        one-cycle start pulse, only honoured in IDLE
//   num_kij_i      kernel positions to run (0 runs one)
//   len_nij_i      activations per kij
//   w_base_i       xmem base of weight tiles (tile k at w_base + k*ROW)
//   x_base_i       xmem base of the activation block
//   p_base_i       pmem base for output rows
//   ofifo_valid_i  OFIFO holds a full row (only looked at in DRAIN)
//   inst_o         core instruction word
//   busy_o         high outside IDLE
//   done_o         one-cycle pulse in the final (FIN) cycle
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start_i
// WFETCH | ROW xmem reads of the current weight tile
// WLOAD  | COL cycles pushing L0 into the array (l0_rd + load)
// WGAP   | LOAD_GAP idle cycles while weights settle
// XFETCH | len_nij xmem reads of the activation block
// EXEC   | len_nij cycles of l0_rd + execute
// ETAIL  | EXEC_TAIL execute-only cycles draining the array into OFIFO
// DRAIN  | one pmem write per ofifo_valid cycle until len_nij rows written
// FIN    | done pulse, back to IDLE

module core_seq_ctrl #(
    parameter int ROW       = 8,
    parameter int COL       = 8,
    parameter int LOAD_GAP  = 16,
    parameter int EXEC_TAIL = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [3:0]  num_kij_i,
    input  logic [10:0] len_nij_i,
    input  logic [10:0] w_base_i,
    input  logic [10:0] x_base_i,
    input  logic [10:0] p_base_i,
    input  logic        ofifo_valid_i,
    output logic [33:0] inst_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [33:0] IDLE_WORD = 34'h1800C0000;

    typedef enum logic [3:0] {
        S_IDLE, S_WFETCH, S_WLOAD, S_WGAP, S_XFETCH,
        S_EXEC, S_ETAIL, S_DRAIN, S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] c_q, c_d;        // cycle counter; doubles as row-write count d in DRAIN
    logic [3:0]  k_q, k_d;
    logic [33:0] inst_q, inst_d;
    logic [3:0]  num_q;
    logic [10:0] len_q, w_base_q, x_base_q, p_base_q;

    logic [10:0] w_tile_off;
    logic        more_kij;
    logic        len_last;

    assign w_tile_off = 11'(k_q * ROW);
    assign more_kij   = ({1'b0, k_q} + 5'd1) < {1'b0, num_q};
    assign len_last   = (c_q == len_q - 11'd1);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        k_d     = k_q;
        inst_d  = IDLE_WORD;
        // l0_wr trails the xmem read strobe by one cycle (read latency)
        inst_d[2] = ~inst_q[19];

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_WFETCH;
                    c_d     = '0;
                    k_d     = '0;
                end
            end
            S_WFETCH: begin
                inst_d[19]   = 1'b0;
                inst_d[17:7] = w_base_q + w_tile_off + c_q;
                if (c_q == 11'(ROW - 1)) begin
                    state_d = S_WLOAD;
                    c_d     = '0;
                end else begin
                    c_d = c_q + 11'd1;
                end
            end
            S_WLOAD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
                if (c_q == 11'(COL - 1)) begin
                    state_d = S_WGAP;
                    c_d     = '0;
                end else begin
                    c_d = c_q + 11'd1;
                end
            end
            S_WGAP: begin
                if (c_q == 11'(LOAD_GAP - 1)) begin
                    state_d = S_XFETCH;
                    c_d     = '0;
                end else begin
                    c_d = c_q + 11'd1;
                end
            end
            S_XFETCH: begin
                inst_d[19]   = 1'b0;
                inst_d[17:7] = x_base_q + c_q;
                if (len_last) begin
                    state_d = S_EXEC;
                    c_d     = '0;
                end else begin
                    c_d = c_q + 11'd1;
                end
            end
            S_EXEC: begin
                inst_d[33] = (k_q != 4'd0);
                inst_d[3]  = 1'b1;
                inst_d[1]  = 1'b1;
                if (len_last) begin
                    state_d = S_ETAIL;
                    c_d     = '0;
                end else begin
                    c_d = c_q + 11'd1;
                end
            end
            S_ETAIL: begin
                inst_d[33] = (k_q != 4'd0);
                inst_d[1]  = 1'b1;
                if (c_q == 11'(EXEC_TAIL - 1)) begin
                    state_d = S_DRAIN;
                    c_d     = '0;
                end else begin
                    c_d = c_q + 11'd1;
                end
            end
            S_DRAIN: begin
                if (ofifo_valid_i) begin
                    inst_d[6]     = 1'b1;
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = p_base_q + c_q;
                    if (len_last) begin
                        c_d = '0;
                        if (more_kij) begin
                            k_d     = k_q + 4'd1;
                            state_d = S_WFETCH;
                        end else begin
                            state_d = S_FIN;
                        end
                    end else begin
                        c_d = c_q + 11'd1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            c_q      <= '0;
            k_q      <= '0;
            inst_q   <= IDLE_WORD;
            num_q    <= '0;
            len_q    <= '0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            k_q     <= k_d;
            inst_q  <= inst_d;
            if (state_q == S_IDLE && start_i) begin
                num_q    <= (num_kij_i == 4'd0) ? 4'd1 : num_kij_i;
                len_q    <= len_nij_i;
                w_base_q <= w_base_i;
                x_base_q <= x_base_i;
                p_base_q <= p_base_i;
            end
        end
    end

    assign inst_o = inst_q;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_FIN);

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;

    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int GAP  = 16;
    localparam int TAIL = 16;
    localparam logic [33:0] IDLE_W = 34'h1800C0000;

    logic        clk = 1'b0;
    logic        reset, start, ofifo_valid;
    logic [3:0]  num_kij;
    logic [10:0] len_nij, w_base, x_base, p_base;
    logic [33:0] inst;
    logic        busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    core_seq_ctrl dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .num_kij_i     (num_kij),
        .len_nij_i     (len_nij),
        .w_base_i      (w_base),
        .x_base_i      (x_base),
        .p_base_i      (p_base),
        .ofifo_valid_i (ofifo_valid),
        .inst_o        (inst),
        .busy_o        (busy),
        .done_o        (done)
    );

    // Reference words built directly from the field map.
    function automatic logic [33:0] w_read(input logic [10:0] a);
        logic [33:0] w = IDLE_W;
        w[19] = 1'b0;
        w[17:7] = a;
        return w;
    endfunction

    function automatic logic [33:0] w_load();
        logic [33:0] w = IDLE_W;
        w[3] = 1'b1;
        w[0] = 1'b1;
        return w;
    endfunction

    function automatic logic [33:0] w_exec(input logic acc, input logic l0rd);
        logic [33:0] w = IDLE_W;
        w[33] = acc;
        w[3]  = l0rd;
        w[1]  = 1'b1;
        return w;
    endfunction

    function automatic logic [33:0] w_write(input logic [10:0] a);
        logic [33:0] w = IDLE_W;
        w[6] = 1'b1;
        w[32] = 1'b0;
        w[31] = 1'b0;
        w[30:20] = a;
        return w;
    endfunction

    // expq holds words expected one cycle later; the word generated by the
    // sequence position of cycle t must show on inst in cycle t+1.
    logic [33:0] expq[$];
    logic [33:0] last_w;
    logic [10:0] obs_wr[$];
    int          done_cnt;
    int          cyc_idx;
    int          stray_at;

    task automatic step(input logic [33:0] w, input logic v, input logic bexp, input logic dexp);
        logic [33:0] e;
        logic [33:0] wn;
        e = expq.pop_front();
        n_cmp++;
        if (inst !== e) begin
            n_bad++;
            $display("FAIL inst cyc=%0d: got %h want %h", cyc_idx, inst, e);
        end
        n_cmp++;
        if (busy !== bexp) begin
            n_bad++;
            $display("FAIL busy cyc=%0d: got %b want %b", cyc_idx, busy, bexp);
        end
        n_cmp++;
        if (done !== dexp) begin
            n_bad++;
            $display("FAIL done cyc=%0d: got %b want %b", cyc_idx, done, dexp);
        end
        if (inst[32] === 1'b0 && inst[31] === 1'b0) obs_wr.push_back(inst[30:20]);
        if (done === 1'b1) done_cnt++;
        if (cyc_idx == stray_at) begin
            start    = 1'b1;
            num_kij  = 4'($urandom);
            len_nij  = 11'($urandom);
            w_base   = 11'($urandom);
            x_base   = 11'($urandom);
            p_base   = 11'($urandom);
        end else begin
            start = 1'b0;
        end
        ofifo_valid = v;
        wn = w;
        wn[2] = ~last_w[19];
        expq.push_back(wn);
        last_w = wn;
        cyc_idx++;
        @(negedge clk);
    endtask

    // vmode: 0 random valid, 1 valid always, 2 valid pattern 1,0,0 in DRAIN.
    task automatic run_seq(input int num, input int len, input int wb, input int xb,
                           input int pb, input int vmode, input int stray);
        int nk;
        int d;
        int di;
        logic v;
        logic [10:0] a;
        num_kij = 4'(num);
        len_nij = 11'(len);
        w_base  = 11'(wb);
        x_base  = 11'(xb);
        p_base  = 11'(pb);
        start   = 1'b1;
        ofifo_valid = 1'($urandom);
        n_cmp++;
        if (inst !== IDLE_W || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_start: inst %h busy %b want %h 0", inst, busy, IDLE_W);
        end
        expq.delete();
        expq.push_back(IDLE_W);
        last_w = IDLE_W;
        obs_wr.delete();
        done_cnt = 0;
        cyc_idx  = 0;
        stray_at = stray;
        @(negedge clk);
        start = 1'b0;
        nk = (num == 0) ? 1 : num;
        for (int k = 0; k < nk; k++) begin
            for (int i = 0; i < ROW; i++) begin
                a = 11'(wb + k * ROW + i);
                step(w_read(a), 1'($urandom), 1'b1, 1'b0);
            end
            for (int i = 0; i < COL; i++) step(w_load(), 1'($urandom), 1'b1, 1'b0);
            for (int i = 0; i < GAP; i++) step(IDLE_W, 1'($urandom), 1'b1, 1'b0);
            for (int i = 0; i < len; i++) begin
                a = 11'(xb + i);
                step(w_read(a), 1'($urandom), 1'b1, 1'b0);
            end
            for (int i = 0; i < len; i++) step(w_exec(k != 0, 1'b1), 1'($urandom), 1'b1, 1'b0);
            for (int i = 0; i < TAIL; i++) step(w_exec(k != 0, 1'b0), 1'($urandom), 1'b1, 1'b0);
            d  = 0;
            di = 0;
            while (d < len) begin
                if (di > 2000) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL drain_bound: got %0d rows want %0d", d, len);
                    break;
                end
                v = (vmode == 1) ? 1'b1 : (vmode == 2) ? (di % 3 == 0) : 1'($urandom);
                a = 11'(pb + d);
                step(v ? w_write(a) : IDLE_W, v, 1'b1, 1'b0);
                if (v) d++;
                di++;
            end
        end
        step(IDLE_W, 1'($urandom), 1'b1, 1'b1);
        step(IDLE_W, 1'b0, 1'b0, 1'b0);
        ofifo_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        ofifo_valid = 1'b0;
        num_kij = '0; len_nij = '0; w_base = '0; x_base = '0; p_base = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1'b0;
            n_cmp++;
            if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state cyc=%0d: inst %h busy %b done %b want %h 0 0",
                         i, inst, busy, done, IDLE_W);
            end
        end
    endtask

    task automatic test_basic();
        run_seq(1, 4, 0, 100, 0, 1, -1);
        n_cmp++;
        if (obs_wr.size() != 4) begin
            n_bad++;
            $display("FAIL basic_nwr: got %0d want 4", obs_wr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (obs_wr[i] !== 11'(i)) begin
                    n_bad++;
                    $display("FAIL basic_addr[%0d]: got %0d want %0d", i, obs_wr[i], i);
                end
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("FAIL basic_done: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_multi_kij();
        run_seq(3, 5, 40, 200, 10, 0, -1);
        n_cmp++;
        if (obs_wr.size() != 15) begin
            n_bad++;
            $display("FAIL multi_nwr: got %0d want 15", obs_wr.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                n_cmp++;
                if (obs_wr[i] !== 11'(10 + i % 5)) begin
                    n_bad++;
                    $display("FAIL multi_addr[%0d]: got %0d want %0d", i, obs_wr[i], 10 + i % 5);
                end
            end
        end
    endtask

    task automatic test_valid_toggle();
        run_seq(0, 4, 7, 300, 500, 2, -1);
        n_cmp++;
        if (obs_wr.size() != 4 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL toggle: got %0d writes %0d done want 4 1", obs_wr.size(), done_cnt);
        end
    endtask

    task automatic test_reset_exec();
        num_kij = 4'd2; len_nij = 11'd4; w_base = 11'd8; x_base = 11'd50; p_base = 11'd60;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (37) @(negedge clk);
        n_cmp++;
        if (inst[1] !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL in_exec: inst %h busy %b want execute=1 busy=1", inst, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL abort cyc=%0d: inst %h busy %b done %b want %h 0 0",
                         i, inst, busy, done, IDLE_W);
            end
            @(negedge clk);
        end
        run_seq(1, 3, 16, 90, 33, 0, -1);
        n_cmp++;
        if (done_cnt != 1 || obs_wr.size() != 3) begin
            n_bad++;
            $display("FAIL after_abort: got %0d done %0d writes want 1 3", done_cnt, obs_wr.size());
        end
    endtask

    task automatic test_wrap_stray();
        logic [10:0] want [4];
        want[0] = 11'd2046; want[1] = 11'd2047; want[2] = 11'd0; want[3] = 11'd1;
        run_seq(1, 4, 2044, 2045, 2046, 0, 5);
        n_cmp++;
        if (obs_wr.size() != 4) begin
            n_bad++;
            $display("FAIL wrap_nwr: got %0d want 4", obs_wr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (obs_wr[i] !== want[i]) begin
                    n_bad++;
                    $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, obs_wr[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int nm, ln, nk;
        for (int t = 0; t < 6; t++) begin
            nm = int'($urandom_range(0, 3));
            ln = int'($urandom_range(1, 6));
            nk = (nm == 0) ? 1 : nm;
            run_seq(nm, ln, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, 2047)), 0, int'($urandom_range(0, 30)));
            n_cmp++;
            if (obs_wr.size() != nk * ln || done_cnt != 1) begin
                n_bad++;
                $display("FAIL random[%0d]: got %0d writes %0d done want %0d 1",
                         t, obs_wr.size(), done_cnt, nk * ln);
            end
        end
    endtask

    initial begin
        stray_at = -1;
        test_reset();
        test_basic();
        test_multi_kij();
        test_valid_toggle();
        test_reset_exec();
        test_wrap_stray();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
